// File: rtl/watchdog_reset_if.sv
// watchdog_reset_if: control strobes in, reset request and status out
interface watchdog_reset_if #(parameter int WIDTH = 16);
    logic             enable;
    logic             kick;
    logic             clr_fired;
    logic             rst_req;
    logic             armed;
    logic             fired;
    logic [WIDTH-1:0] count;
    modport master (output enable, kick, clr_fired, input rst_req, armed, fired, count);
    modport slave (input enable, kick, clr_fired, output rst_req, armed, fired, count);
endinterface

// File: rtl/watchdog_reset.sv
// watchdog_reset: kickable watchdog driving a fixed-length reset request; sticky fired flag.
// Define WDT_WINDOW_EN to treat kicks arriving before WINDOW counts as an immediate fire.
module watchdog_reset #(
    parameter int TIMEOUT = 25000,
    parameter int PULSE   = 500,
    parameter int WIDTH   = 16,
    parameter int WINDOW  = 1000
) (
    input logic             clk,
    input logic             reset,
    watchdog_reset_if.slave bus
);
    typedef enum logic [1:0] {DISABLED, ARMED, FIRING} state_t;
    localparam logic [WIDTH-1:0] T_LAST = WIDTH'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] P_LAST = WIDTH'(PULSE - 1);
    if (TIMEOUT < 2 || PULSE < 1 || WINDOW >= TIMEOUT) begin : g_bad_params
        $error("watchdog_reset: illegal TIMEOUT/PULSE/WINDOW");
    end
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             rst_req_q, rst_req_d;
    logic             armed_q, armed_d;
    logic             fired_q = 1'b0;
    logic             fired_d;
    logic             early;
`ifdef WDT_WINDOW_EN
    assign early = bus.kick && (count_q < WIDTH'(WINDOW));
`else
    assign early = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DISABLED;
            count_q   <= '0;
            rst_req_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rst_req_q <= rst_req_d;
            armed_q   <= armed_d;
        end
        fired_q <= fired_d;
    end
    always_comb begin
        state_d = state_q;
        count_d = count_q + 1'b1;
        case (state_q)
            DISABLED: begin
                state_d = bus.enable ? ARMED : DISABLED;
                count_d = '0;
            end
            ARMED: begin
                if (!bus.enable) begin
                    state_d = DISABLED;
                    count_d = '0;
                end else if (early || (!bus.kick && count_q == T_LAST)) begin
                    state_d = FIRING;
                    count_d = '0;
                end else if (bus.kick) begin
                    count_d = '0;
                end
            end
            FIRING: begin
                if (count_q == P_LAST) begin
                    state_d = DISABLED;
                    count_d = '0;
                end
            end
            default: begin
                state_d = DISABLED;
                count_d = '0;
            end
        endcase
    end
    // fired survives reset; entering FIRING beats a same-edge clear
    always_comb begin
        armed_d   = state_d == ARMED;
        rst_req_d = state_d == FIRING;
        fired_d   = (!reset && rst_req_d && !rst_req_q) ? 1'b1 : bus.clr_fired ? 1'b0 : fired_q;
    end
    assign bus.rst_req = rst_req_q;
    assign bus.armed   = armed_q;
    assign bus.fired   = fired_q;
    assign bus.count   = count_q;
endmodule
